uart_rx_frame_parser: RTL and testbench
=======================================

# uart_rx_frame_parser

Byte-level frame parser sitting directly downstream of the UART receiver. It consumes the receiver's one-cycle data-valid strobe and byte, delineates frames of the form SOF, LEN, payload, CHK, and verifies an XOR checksum. Each good frame is buffered and replayed to the system as a valid/ready byte stream with a last marker. Framing, length, checksum and inter-byte timeout errors are reported as one-cycle pulses.

## Interface
- CLKS_PER_BIT, 217: sys_clk cycles per UART bit; must match the receiver.
- TIMEOUT_BITS, 20: inter-byte timeout in bit periods (LIMIT = TIMEOUT_BITS*CLKS_PER_BIT cycles).
- MAX_LEN, 16: maximum payload bytes; LEN width LW = $clog2(MAX_LEN+1).
- SOF, 8'hA5: start-of-frame byte.
- sys_clk  in  1  system clock, 50 MHz.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_DV  in  1  one-cycle strobe: i_rx_data holds a received byte.
- i_rx_data  in  8  received byte.
- o_frm_valid  out  1  output byte valid.
- i_frm_ready  in  1  downstream accepts the byte when valid && ready.
- o_frm_data  out  8  payload byte.
- o_frm_last  out  1  high with the final payload byte.
- o_frm_len  out  LW  LEN of the frame being drained; stable while o_frm_valid.
- o_err_len  out  1  pulse: LEN == 0 or LEN > MAX_LEN.
- o_err_chk  out  1  pulse: checksum mismatch.
- o_err_timeout  out  1  pulse: inter-byte timeout expired.
- o_drop  out  1  pulse: byte arrived during DRAIN and was discarded.

## Operation
- Reset: all outputs 0, state IDLE, counters and running checksum 0.
- IDLE: on i_rx_DV with data == SOF -> LEN. Other bytes are ignored silently.
- LEN: on strobe, byte 1..MAX_LEN -> latch len, chk = byte, idx = 0, go to PAYLOAD. Otherwise pulse o_err_len and go to IDLE.
- PAYLOAD: each strobe writes buf[idx], chk ^= byte, idx++. The strobe with idx == len-1 moves to CHK.
- CHK: on strobe, byte == chk -> DRAIN with rd = 0. Otherwise pulse o_err_chk and go to IDLE.
- DRAIN: o_frm_valid = 1, o_frm_data = buf[rd], o_frm_last = (rd == len-1). On handshake rd++. A handshake with last -> IDLE. Strobes in DRAIN pulse o_drop, and the byte is discarded, including SOF.
- Timeout: in LEN/PAYLOAD/CHK, tcnt counts cycles since the last strobe. It clears on each strobe and on entry from IDLE. When tcnt reaches LIMIT-1: pulse o_err_timeout and go to IDLE. No timeout in IDLE or DRAIN.
- Checksum: 8-bit XOR of LEN and all payload bytes; SOF and CHK are excluded.

## Timing
- All outputs are registered. Error pulses and o_drop last exactly one cycle, in the cycle after the triggering strobe or timeout.
- o_frm_valid rises the cycle after the CHK strobe. One byte per cycle is delivered when i_frm_ready is held high. A len-N frame drains in N cycles minimum.
- o_frm_data, o_frm_last and o_frm_len hold while valid && !ready. Valid never drops before the handshake.
- A strobe in the same cycle that tcnt hits LIMIT-1: the strobe wins and no timeout occurs.
- A last handshake and a simultaneous strobe: the strobe is dropped (o_drop). The parser is back in IDLE the next cycle.
- Asynchronous reset mid-frame or mid-drain: outputs clear immediately. Buffer contents are don't-care.
- Width: tcnt = $clog2(LIMIT) bits; idx and rd = $clog2(MAX_LEN) bits, no wrap since len <= MAX_LEN.

## Structure
- Shared package uart_pkg: state encoding (IDLE, LEN, PAYLOAD, CHK, DRAIN), SOF default, and the LW helper.
- Sub-module uart_frame_buf: MAX_LEN x 8 register array with 1 write port and 1 asynchronous read port, no reset on storage.
- The FSM, counters and checksum live in the top level.

## Test plan
- A5 03 11 22 33 03, ready = 1: 11, 22, 33 are output on consecutive cycles, last on 33, o_frm_len = 3, no error pulses.
- Same frame with CHK = 04: one o_err_chk pulse, o_frm_valid never rises, and the next good frame parses normally.
- A5 00 and A5 11 (MAX_LEN = 16): one o_err_len pulse each; a following A5 01 7E 7F outputs 7E with last.
- A5 02 10, then silence for LIMIT cycles: one o_err_timeout pulse, and a subsequent full frame is accepted.
- Good frame drained with ready toggling 1, 0, 0, 1, plus a byte strobed mid-drain: data holds during stalls, one o_drop pulse, and the payload order is intact.
- i_rst pulsed during PAYLOAD of A5 04 01 02: all outputs 0 immediately; after release, A5 01 55 54 outputs 55 with last.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: parser state encoding, default start-of-frame byte and the LEN width helper.
package uart_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CHK, ST_DRAIN} state_t;
   localparam logic [7:0] SOF_DEFAULT = 8'hA5;
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload store with one write port and an asynchronous read port.
// Storage is deliberately left unreset; only bytes of a verified frame are ever read.
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);
   logic [7:0] mem_q [DEPTH];
   always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: delineates SOF/LEN/payload/CHK frames from UART receiver strobes,
// verifies the XOR checksum and replays good payloads as a valid/ready stream.
module uart_rx_frame_parser
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int TIMEOUT_BITS = 20,
   parameter int MAX_LEN = 16,
   parameter logic [7:0] SOF = SOF_DEFAULT,
   localparam int LW = len_width(MAX_LEN)
) (
   input  logic          sys_clk,
   input  logic          i_rst,
   input  logic          i_rx_DV,
   input  logic [7:0]    i_rx_data,
   output logic          o_frm_valid,
   input  logic          i_frm_ready,
   output logic [7:0]    o_frm_data,
   output logic          o_frm_last,
   output logic [LW-1:0] o_frm_len,
   output logic          o_err_len,
   output logic          o_err_chk,
   output logic          o_err_timeout,
   output logic          o_drop
);
   localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW = $clog2(LIMIT);
   localparam int IW = $clog2(MAX_LEN);

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [7:0]    chk_q, chk_d;
   logic [IW-1:0] idx_q, idx_d, rd_q, rd_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          err_len_q, err_len_d, err_chk_q, err_chk_d;
   logic          err_to_q, err_to_d, drop_q, drop_d;
   logic          buf_we, valid, last, len_ok, timeout, receiving;
   logic [7:0]    rd_data;

   assign valid     = state_q == ST_DRAIN;
   assign last      = LW'(rd_q) == len_q - LW'(1);
   assign len_ok    = i_rx_data != 8'd0 && i_rx_data <= 8'(MAX_LEN);
   assign timeout   = tcnt_q == TW'(LIMIT - 1);
   assign receiving = state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK;

   uart_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
      .clk   (sys_clk),
      .we    (buf_we),
      .waddr (idx_q),
      .wdata (i_rx_data),
      .raddr (rd_q),
      .rdata (rd_data)
   );

   // tcnt defaults to zero so every strobe, and every IDLE/DRAIN cycle, restarts the timeout
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      chk_d     = chk_q;
      idx_d     = idx_q;
      rd_d      = rd_q;
      tcnt_d    = '0;
      err_len_d = 1'b0;
      err_chk_d = 1'b0;
      err_to_d  = 1'b0;
      drop_d    = 1'b0;
      buf_we    = 1'b0;
      if (receiving && !i_rx_DV) begin
         if (timeout) begin
            err_to_d = 1'b1;
            state_d  = ST_IDLE;
         end else tcnt_d = tcnt_q + TW'(1);
      end
      case (state_q)
         ST_IDLE: if (i_rx_DV && i_rx_data == SOF) state_d = ST_LEN;
         ST_LEN: if (i_rx_DV) begin
            if (len_ok) begin
               len_d   = LW'(i_rx_data);
               chk_d   = i_rx_data;
               idx_d   = '0;
               state_d = ST_PAYLOAD;
            end else begin
               err_len_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_PAYLOAD: if (i_rx_DV) begin
            buf_we = 1'b1;
            chk_d  = chk_q ^ i_rx_data;
            idx_d  = idx_q + IW'(1);
            if (LW'(idx_q) == len_q - LW'(1)) state_d = ST_CHK;
         end
         ST_CHK: if (i_rx_DV) begin
            if (i_rx_data == chk_q) begin
               rd_d    = '0;
               state_d = ST_DRAIN;
            end else begin
               err_chk_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            drop_d = i_rx_DV;
            if (i_frm_ready) begin
               rd_d = rd_q + IW'(1);
               if (last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         chk_q     <= '0;
         idx_q     <= '0;
         rd_q      <= '0;
         tcnt_q    <= '0;
         err_len_q <= 1'b0;
         err_chk_q <= 1'b0;
         err_to_q  <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         chk_q     <= chk_d;
         idx_q     <= idx_d;
         rd_q      <= rd_d;
         tcnt_q    <= tcnt_d;
         err_len_q <= err_len_d;
         err_chk_q <= err_chk_d;
         err_to_q  <= err_to_d;
         drop_q    <= drop_d;
      end
   end

   // stream outputs are forced to zero outside DRAIN so reset clears them regardless of buffer contents
   assign o_frm_valid   = valid;
   assign o_frm_data    = valid ? rd_data : 8'd0;
   assign o_frm_last    = valid && last;
   assign o_frm_len     = valid ? len_q : '0;
   assign o_err_len     = err_len_q;
   assign o_err_chk     = err_chk_q;
   assign o_err_timeout = err_to_q;
   assign o_drop        = drop_q;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser: frame-level model predicts payload streams and error pulses;
// every clock cycle passes through step(), which compares the DUT against that model.
module tb_uart_rx_frame_parser;
   localparam int LIMIT = 20 * 217;
   localparam int MAXL = 16;
   typedef logic [7:0] bq_t [$];
   typedef struct packed {logic [7:0] d; logic last; logic [4:0] len;} exp_t;

   logic       sys_clk = 1'b0, i_rst = 1'b1, i_rx_DV = 1'b0, i_frm_ready = 1'b1;
   logic [7:0] i_rx_data = 8'd0;
   logic       o_frm_valid, o_frm_last, o_err_len, o_err_chk, o_err_timeout, o_drop;
   logic [7:0] o_frm_data;
   logic [4:0] o_frm_len;

   int   errors = 0, checks = 0;
   int   exp_len = 0, exp_chk = 0, exp_to = 0, exp_drop = 0;
   int   seen_len = 0, seen_chk = 0, seen_to = 0, seen_drop = 0;
   exp_t exp_q [$];
   logic stall_prev = 1'b0;
   logic [3:0] prev_p = 4'd0;

   always #10 sys_clk = ~sys_clk;

   uart_rx_frame_parser dut (
      .sys_clk       (sys_clk),
      .i_rst         (i_rst),
      .i_rx_DV       (i_rx_DV),
      .i_rx_data     (i_rx_data),
      .o_frm_valid   (o_frm_valid),
      .i_frm_ready   (i_frm_ready),
      .o_frm_data    (o_frm_data),
      .o_frm_last    (o_frm_last),
      .o_frm_len     (o_frm_len),
      .o_err_len     (o_err_len),
      .o_err_chk     (o_err_chk),
      .o_err_timeout (o_err_timeout),
      .o_drop        (o_drop)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // one clock cycle: compare on the falling edge, return just after the next rising edge
   task automatic step();
      @(negedge sys_clk);
      if (o_frm_valid) begin
         if (exp_q.size() == 0) check("unexpected_valid", 32'(o_frm_valid), 0);
         else begin
            check("frm_data", 32'(o_frm_data), 32'(exp_q[0].d));
            check("frm_last", 32'(o_frm_last), 32'(exp_q[0].last));
            check("frm_len", 32'(o_frm_len), 32'(exp_q[0].len));
            if (i_frm_ready) void'(exp_q.pop_front());
         end
      end
      if (stall_prev) check("valid_held", 32'(o_frm_valid), 1);
      stall_prev = o_frm_valid && !i_frm_ready;
      if (o_err_len) check("err_len_1cyc", 32'(prev_p[0]), 0);
      if (o_err_chk) check("err_chk_1cyc", 32'(prev_p[1]), 0);
      if (o_err_timeout) check("err_to_1cyc", 32'(prev_p[2]), 0);
      if (o_drop) check("drop_1cyc", 32'(prev_p[3]), 0);
      seen_len += int'(o_err_len);
      seen_chk += int'(o_err_chk);
      seen_to += int'(o_err_timeout);
      seen_drop += int'(o_drop);
      prev_p = {o_drop, o_err_timeout, o_err_chk, o_err_len};
      @(posedge sys_clk);
      #1;
   endtask

   function automatic logic [7:0] xor_of(input bq_t b);
      logic [7:0] x = 8'd0;
      foreach (b[i]) x ^= b[i];
      return x;
   endfunction

   // f = SOF, LEN, payload..., CHK
   task automatic expect_frame(input bq_t f);
      int n = int'(f[1]);
      bq_t body;
      if (n == 0 || n > MAXL) exp_len++;
      else begin
         for (int i = 0; i <= n; i++) body.push_back(f[i + 1]);
         if (f[n + 2] != xor_of(body)) exp_chk++;
         else for (int i = 0; i < n; i++) exp_q.push_back('{d: f[i + 2], last: (i == n - 1), len: 5'(n)});
      end
   endtask

   task automatic send(input logic [7:0] b);
      i_rx_DV = 1'b1;
      i_rx_data = b;
      step();
      i_rx_DV = 1'b0;
   endtask

   task automatic send_frame(input bq_t f, input bit model);
      if (model) expect_frame(f);
      foreach (f[i]) begin
         send(f[i]);
         if (i != f.size() - 1) begin
            step();
            step();
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic counts(input string tag);
      check({tag, "_n_err_len"}, 32'(seen_len), 32'(exp_len));
      check({tag, "_n_err_chk"}, 32'(seen_chk), 32'(exp_chk));
      check({tag, "_n_err_to"}, 32'(seen_to), 32'(exp_to));
      check({tag, "_n_drop"}, 32'(seen_drop), 32'(exp_drop));
      check({tag, "_queue_left"}, 32'(exp_q.size()), 0);
   endtask

   task automatic check_all_zero(input string name);
      check(name, 32'({o_frm_valid, o_frm_data, o_frm_last, o_frm_len,
                       o_err_len, o_err_chk, o_err_timeout, o_drop}), 0);
   endtask

   initial begin
      bq_t f;
      idle(3);
      check_all_zero("reset_outputs");
      i_rst = 1'b0;
      idle(2);
      f = '{8'h03, 8'h11, 8'h22, 8'h33};
      check("model_xor_len3", 32'(xor_of(f)), 32'h03);

      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_frame(f, 1);
      check("t1_valid", 32'(o_frm_valid), 1);
      check("t1_d0", 32'(o_frm_data), 32'h11);
      check("t1_last0", 32'(o_frm_last), 0);
      check("t1_len", 32'(o_frm_len), 3);
      step();
      check("t1_d1", 32'(o_frm_data), 32'h22);
      step();
      check("t1_d2", 32'(o_frm_data), 32'h33);
      check("t1_last2", 32'(o_frm_last), 1);
      step();
      check("t1_done", 32'(o_frm_valid), 0);
      idle(4);
      counts("t1");

      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
      send_frame(f, 1);
      check("t2_err_chk", 32'(o_err_chk), 1);
      check("t2_no_valid", 32'(o_frm_valid), 0);
      idle(3);
      check("t2_chk_total", 32'(seen_chk), 1);
      f = '{8'hA5, 8'h02, 8'hF0, 8'h0F, 8'hFD};
      send_frame(f, 1);
      idle(6);
      counts("t2");

      f = '{8'hA5, 8'h00};
      send_frame(f, 1);
      check("t3_err_len0", 32'(o_err_len), 1);
      idle(3);
      f = '{8'hA5, 8'h11};
      send_frame(f, 1);
      check("t3_err_len17", 32'(o_err_len), 1);
      idle(3);
      check("t3_len_total", 32'(seen_len), 2);
      f = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_frame(f, 1);
      check("t3_d", 32'(o_frm_data), 32'h7E);
      check("t3_last", 32'(o_frm_last), 1);
      idle(4);
      counts("t3");

      f = '{8'hA5, 8'h02, 8'h10};
      send_frame(f, 0);
      exp_to++;
      idle(LIMIT - 1);
      check("t4_no_early_to", 32'(o_err_timeout), 0);
      step();
      check("t4_to_pulse", 32'(o_err_timeout), 1);
      step();
      check("t4_to_end", 32'(o_err_timeout), 0);
      f = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_frame(f, 1);
      idle(4);
      f = '{8'hA5, 8'h01, 8'h33, 8'h32};
      expect_frame(f);
      send(8'hA5);
      idle(LIMIT - 1);
      send(8'h01);
      check("t4_strobe_wins", 32'(o_err_timeout), 0);
      step();
      send(8'h33);
      step();
      send(8'h32);
      idle(4);
      counts("t4");

      f = '{8'hA5, 8'h04, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h00};
      send_frame(f, 1);
      step();
      i_frm_ready = 1'b0;
      step();
      check("t5_hold1", 32'(o_frm_data), 32'hD2);
      i_rx_DV = 1'b1;
      i_rx_data = 8'hA5;
      exp_drop++;
      step();
      i_rx_DV = 1'b0;
      check("t5_drop", 32'(o_drop), 1);
      check("t5_hold2", 32'(o_frm_data), 32'hD2);
      i_frm_ready = 1'b1;
      step();
      check("t5_drop_end", 32'(o_drop), 0);
      step();
      check("t5_d3", 32'(o_frm_data), 32'hD4);
      check("t5_last", 32'(o_frm_last), 1);
      idle(4);
      counts("t5");

      f = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_frame(f, 1);
      i_rx_DV = 1'b1;
      i_rx_data = 8'hA5;
      exp_drop++;
      step();
      i_rx_DV = 1'b0;
      check("t6_drop", 32'(o_drop), 1);
      check("t6_idle", 32'(o_frm_valid), 0);
      f = '{8'h01, 8'h7E, 8'h7F};
      send_frame(f, 0);
      idle(4);
      counts("t6");

      f = '{8'hA5, 8'h04, 8'h01, 8'h02};
      send_frame(f, 0);
      step();
      i_rst = 1'b1;
      #2;
      check_all_zero("t7_rst_payload");
      idle(2);
      i_rst = 1'b0;
      step();
      f = '{8'hA5, 8'h01, 8'h55, 8'h54};
      send_frame(f, 1);
      check("t7_d", 32'(o_frm_data), 32'h55);
      check("t7_last", 32'(o_frm_last), 1);
      idle(4);
      counts("t7");

      i_frm_ready = 1'b0;
      f = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13};
      send_frame(f, 1);
      step();
      check("t8_stalled", 32'(o_frm_data), 32'hAA);
      i_rst = 1'b1;
      #2;
      check_all_zero("t8_rst_drain");
      exp_q.delete();
      stall_prev = 1'b0;
      idle(2);
      i_rst = 1'b0;
      i_frm_ready = 1'b1;
      idle(4);
      counts("t8");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
